// File: rtl/fifo_fir_mac.sv
// fifo_fir_mac
//   Time-multiplexed direct-form FIR that consumes signed samples from the read
//   side of an async FIFO. One sample is popped per pass. A single multiplier
//   then walks all taps, one tap per cycle, and the full-precision sum is
//   presented on a valid/ready output. Coefficients are written at run time,
//   and only while the block is idle.
//
// Ports
//   rd_clk      sole clock (FIFO read clock)
//   rst_fir     synchronous active-high reset
//   fifo_data   FIFO data_out, valid the cycle after rd_en
//   fifo_empty  FIFO empty flag
//   rd_en       FIFO pop strobe (combinational)
//   coef_wr_en  coefficient write strobe (honoured only in IDLE)
//   coef_addr   tap index k; h[k] multiplies x[n-k]
//   coef_data   signed coefficient value
//   out_data    y[n] = sum h[k]*x[n-k], signed full precision
//   out_valid   out_data valid; held until out_ready
//   out_ready   downstream accept
//   busy        high whenever the FSM is not in IDLE
module fifo_fir_mac #(
  parameter int DATA_LENGTH = 24,
  parameter int COEF_WIDTH  = 18,
  parameter int NUM_TAPS    = 16,
  parameter int TAP_AW      = $clog2(NUM_TAPS),
  parameter int ACC_WIDTH   = DATA_LENGTH + COEF_WIDTH + TAP_AW
) (
  input  logic                          rd_clk,
  input  logic                          rst_fir,
  input  logic signed [DATA_LENGTH-1:0] fifo_data,
  input  logic                          fifo_empty,
  output logic                          rd_en,
  input  logic                          coef_wr_en,
  input  logic        [TAP_AW-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic signed [ACC_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int PROD_WIDTH = DATA_LENGTH + COEF_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;

  state_t state;
  state_t state_next;

  logic signed [DATA_LENGTH-1:0] delay [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  coef  [NUM_TAPS];
  logic        [TAP_AW-1:0]      head;
  logic        [TAP_AW-1:0]      tap;
  logic        [TAP_AW-1:0]      x_idx;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [PROD_WIDTH-1:0]  mul_x;
  logic signed [PROD_WIDTH-1:0]  mul_h;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic                          pop;
  logic                          last_tap;

  // A write in the same cycle wins over a pop, so pop is suppressed by coef_wr_en.
  assign pop      = (state == IDLE) && !fifo_empty && !coef_wr_en;
  assign last_tap = (tap == TAP_AW'(NUM_TAPS - 1));

  // The delay line is circular; x[n-k] lives at (head-k) mod NUM_TAPS, and the
  // power-of-two length makes the TAP_AW-bit subtraction wrap for free.
  assign x_idx   = head - tap;
  assign mul_x   = PROD_WIDTH'(delay[x_idx]);
  assign mul_h   = PROD_WIDTH'(coef[tap]);
  assign acc_sum = acc + ACC_WIDTH'(prod);

  always_ff @(posedge rd_clk) begin
    if (rst_fir) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (last_tap) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pop strobe is masked by reset so that no FIFO word is lost while the
  // FSM is being forced back to IDLE.
  always_comb begin
    rd_en = pop && !rst_fir;
    busy  = (state != IDLE);
  end

  // The product is registered, so the accumulator trails the multiplier by one
  // cycle. The first MAC cycle has nothing to add yet, and DRAIN folds in the
  // last tap. The result is also captured into out_data on the way into OUT.
  always_ff @(posedge rd_clk) begin
    if (rst_fir) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= '0;
      end
      head      <= '0;
      tap       <= '0;
      prod      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_wr_en) coef[coef_addr] <= coef_data;
        end
        LOAD: begin
          delay[head] <= fifo_data;
          acc         <= '0;
          tap         <= '0;
        end
        MAC: begin
          prod <= mul_x * mul_h;
          if (tap != '0) acc <= acc_sum;
          tap <= tap + TAP_AW'(1);
        end
        DRAIN: begin
          acc       <= acc_sum;
          out_data  <= acc_sum;
          out_valid <= 1'b1;
          head      <= head + TAP_AW'(1);
        end
        OUT: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fir_mac.sv
// tb_fifo_fir_mac
//   Self-checking bench for fifo_fir_mac with a 4-tap filter. It contains a FIFO
//   model plus a behavioural reference. The reference keeps the last NUM_TAPS
//   samples and the coefficients as plain arrays, and it computes each output
//   as a direct dot product at pop time. A phase/countdown tracks when the block
//   should be busy and when the result should appear. Directed sections
//   exercise reset, impulse response, backpressure, an empty FIFO, extreme
//   values, ignored coefficient writes and reset during MAC. A randomized
//   section follows.
module tb_fifo_fir_mac;

  localparam int DL    = 24;
  localparam int CW    = 18;
  localparam int NT    = 4;
  localparam int AW    = $clog2(NT);
  localparam int ACC_W = DL + CW + AW;

  logic                    rd_clk = 1'b0;
  logic                    rst_fir;
  logic signed [DL-1:0]    fifo_data;
  logic                    fifo_empty;
  logic                    rd_en;
  logic                    coef_wr_en;
  logic        [AW-1:0]    coef_addr;
  logic signed [CW-1:0]    coef_data;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  always #5 rd_clk = ~rd_clk;

  fifo_fir_mac #(
    .DATA_LENGTH(DL),
    .COEF_WIDTH (CW),
    .NUM_TAPS   (NT)
  ) dut (
    .rd_clk    (rd_clk),
    .rst_fir   (rst_fir),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .rd_en     (rd_en),
    .coef_wr_en(coef_wr_en),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  // FIFO model: words are queued here; a popped word shows up on fifo_data
  // the following cycle, and garbage is driven otherwise.
  logic [DL-1:0] fifo_q[$];
  logic [DL-1:0] pop_val;
  bit            pop_last;

  // Reference model: phase 0 idle, 1 computing (countdown), 2 result pending.
  longint m_h[NT];
  longint m_hist[NT];
  int     m_phase;
  int     m_count;
  longint m_next_y;
  longint m_out;
  bit     exp_rd_en;

  logic signed [63:0] got[$];

  task automatic check_val(input string name, input logic signed [63:0] actual,
                           input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_h[k]    = 0;
      m_hist[k] = 0;
    end
    m_phase  = 0;
    m_count  = 0;
    m_next_y = 0;
    m_out    = 0;
  endtask

  task automatic check_output();
    check_val("rd_en", 64'(rd_en), 64'(exp_rd_en));
    check_val("busy", 64'(busy), 64'(m_phase != 0));
    check_val("out_valid", 64'(out_valid), 64'(m_phase == 2));
    check_val("out_data", 64'($signed(out_data)), m_out);
    if (out_valid === 1'b1 && out_ready) got.push_back(64'($signed(out_data)));
  endtask

  // Advances the reference model across the upcoming rising edge.
  task automatic model_step();
    if (rst_fir) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          if (coef_wr_en) begin
            m_h[coef_addr] = longint'($signed(coef_data));
          end else if (exp_rd_en) begin
            pop_val  = fifo_q.pop_front();
            pop_last = 1'b1;
            for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = longint'($signed(pop_val));
            m_next_y = 0;
            for (int k = 0; k < NT; k++) m_next_y += m_h[k] * m_hist[k];
            m_phase = 1;
            m_count = NT + 2;
          end
        end
        1: begin
          m_count--;
          if (m_count == 0) begin
            m_phase = 2;
            m_out   = m_next_y;
          end
        end
        default: begin
          if (out_ready) m_phase = 0;
        end
      endcase
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic apply_stimulus(input bit rst, input bit force_empty, input bit wr,
                                input int addr, input longint cdata, input bit ready);
    @(negedge rd_clk);
    fifo_data  = pop_last ? pop_val : DL'($urandom);
    pop_last   = 1'b0;
    rst_fir    = rst;
    fifo_empty = force_empty || (fifo_q.size() == 0);
    coef_wr_en = wr;
    coef_addr  = AW'(addr);
    coef_data  = CW'(cdata);
    out_ready  = ready;
    exp_rd_en  = !rst && (m_phase == 0) && !fifo_empty && !wr;
    #1;
    check_output();
    model_step();
  endtask

  task automatic run_cycles(input int n, input bit force_empty, input bit ready);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, force_empty, 1'b0, 0, 0, ready);
  endtask

  task automatic check_got(input string name, input int idx, input logic signed [63:0] expected);
    check_val(name, (idx < got.size()) ? got[idx] : 64'hx, expected);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit any_pop;
    int e2[5];

    rst_fir    = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    coef_wr_en = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    out_ready  = 1'b0;
    pop_last   = 1'b0;
    pop_val    = '0;
    model_reset();
    @(posedge rd_clk);

    // Reset held with a non-empty FIFO: no pop may happen.
    fifo_q.push_back(24'h123456);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    fifo_q.delete();
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_out_data", 64'($signed(out_data)), 64'd0);

    // Impulse response with h = 1,2,3,4.
    for (int k = 0; k < NT; k++) apply_stimulus(1'b0, 1'b0, 1'b1, k, k + 1, 1'b1);
    fifo_q.push_back(24'd1);
    for (int i = 0; i < 4; i++) fifo_q.push_back(24'd0);
    got.delete();
    run_cycles(5 * (NT + 4) + 4, 1'b0, 1'b1);
    e2 = '{1, 2, 3, 4, 0};
    check_val("impulse_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) check_got($sformatf("impulse_y%0d", i), i, 64'(e2[i]));

    // Backpressure: result held, no pop, a single-cycle ready gives one transfer.
    got.delete();
    fifo_q.push_back(24'd5);
    fifo_q.push_back(24'd6);
    run_cycles(NT + 3 + 10, 1'b0, 1'b0);
    check_val("bp_valid_held", 64'(out_valid), 64'd1);
    check_val("bp_no_transfer", 64'(got.size()), 64'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_cycles(NT + 3 + 5, 1'b0, 1'b0);
    check_val("bp_one_transfer", 64'(got.size()), 64'd1);
    check_got("bp_y", 0, 64'd5);
    run_cycles(NT + 4, 1'b1, 1'b1);
    check_got("bp_y_next", 1, 64'd16);

    // FIFO empty for 50 cycles, then empty drops.
    fifo_q.push_back(24'd9);
    any_pop = 1'b0;
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      any_pop |= rd_en;
    end
    check_val("empty_no_pop", 64'(any_pop), 64'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    check_val("empty_drop_rd_en", 64'(rd_en), 64'd1);
    run_cycles(NT + 5, 1'b0, 1'b1);

    // Most negative samples and coefficients: large positive sum, no wrap.
    for (int k = 0; k < NT; k++) apply_stimulus(1'b0, 1'b0, 1'b1, k, -131072, 1'b1);
    for (int i = 0; i < NT; i++) fifo_q.push_back(24'h800000);
    got.delete();
    run_cycles(NT * (NT + 4) + 4, 1'b0, 1'b1);
    check_val("extreme_count", 64'(got.size()), 64'(NT));
    check_got("extreme_y", NT - 1, 64'sd4398046511104);

    // Coefficient writes while busy are ignored.
    fifo_q.push_back(24'd3);
    got.delete();
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < NT + 2; i++) apply_stimulus(1'b0, 1'b0, 1'b1, i % NT, 17, 1'b1);
    run_cycles(4, 1'b0, 1'b1);
    check_got("busy_wr_ignored_y", 0, 64'sd3298534490112);

    // Reset in the middle of MAC clears history and coefficients.
    fifo_q.push_back(24'd100);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_cycles(3, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_out_valid", 64'(out_valid), 64'd0);
    fifo_q.push_back(24'd55);
    got.delete();
    run_cycles(NT + 5, 1'b0, 1'b1);
    check_val("midrst_count", 64'(got.size()), 64'd1);
    check_got("midrst_y", 0, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() < 3) fifo_q.push_back(DL'($urandom));
      apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 6) == 0, int'($urandom_range(0, NT - 1)),
                     longint'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
